seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Output-side counterpart to the button input conditioning path. Takes a
//  signed calculator result (sign + 14-bit magnitude), converts it to BCD
//  sequentially (shift-add-3), and time-multiplexes four common-anode digits.
//  Sits between the calculator datapath and the board's 7-segment pins.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (1 kHz/digit at 100 MHz); >=2
//  MAG_W        14      magnitude width; conversion takes MAG_W shift cycles
// PORTS
//  clk       in   1      system clock, all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  value     in   MAG_W  unsigned magnitude to display
//  negative  in   1      sign of value; 1 = show leading minus
//  load      in   1      1-cycle request; sampled with value/negative
//  busy      out  1      conversion in progress; load ignored while high
//  an        out  4      digit enables, active-low; an[0] = rightmost digit
//  seg       out  7      {g,f,e,d,c,b,a}, active-low
//  dp        out  1      decimal point, active-low; always 1 (off)
// BEHAVIOUR
//  Reset: an=4'b1111, seg=7'h7F, dp=1, busy=0, all four display codes BLANK,
//   scan index=0, refresh counter=0. Reset mid-conversion aborts it; no
//   partial result is ever shown.
//  Handshake: load && !busy accepts value/negative that cycle; busy=1 from the
//   next cycle for exactly MAG_W+1 cycles (1 capture + MAG_W shift steps).
//   The 4-digit display register updates atomically on the last busy cycle;
//   busy=0 the cycle after. load while busy=1 is dropped, no queuing.
//  Conversion: shift-add-3 on 16-bit BCD accumulator; add 3 to each nibble >=5
//   before each left shift. Purely sequential, one shift per cycle.
//  Formatting (applied when committing to display register):
//   - value > 9999, or negative && value > 999: all four digits DASH.
//   - else leading zeros -> BLANK; digit 0 always shown (0 shows "   0").
//   - negative && value != 0: MINUS in the digit left of the most-significant
//     non-blank digit. negative with value 0 shows "   0" (no -0).
//  Scan: refresh counter counts 0..REFRESH_DIV-1 then wraps; on wrap scan index
//   increments 3->0 wraps. an/seg registered: reflect new index one cycle
//   after the wrap. Exactly one an bit low at any time after first wrap.
//   Display register update mid-slot takes effect at next registered output;
//   no blanking glitch required.
//  Codes: 0-9 digit, BLANK -> seg 7'h7F, MINUS/DASH -> g only (7'h3F).
// STRUCTURE
//  Shared package: 4-bit display code constants (CODE_BLANK=4'hA,
//   CODE_MINUS=4'hB), active-low segment patterns for 0-9/blank/minus,
//   DIGITS=4.
//  One sub-module: seg7_decoder (combinational code[3:0] -> seg[6:0]).
//  Top holds conversion FSM (IDLE, CONVERT, COMMIT), refresh counter, scan
//   index, display register, output registers.
// TESTING  (REFRESH_DIV=4 in sim)
//  Reset asserted async mid-slot -> an=1111, seg=7F, busy=0 immediately.
//  load value=1234 neg=0 -> busy high 15 cycles; scan shows an0:4 an1:3
//   an2:2 an3:1 (seg 19,30,24,79).
//  load value=7 neg=1 -> an0:7(78) an1:MINUS(3F) an2,an3 blank(7F).
//  load value=10000, then value=1000 neg=1 -> both show four dashes (3F).
//  load 42 then load 99 three cycles later (busy) -> 99 ignored, shows "  42".
//  load 5555, rst pulse at busy cycle 8 -> all blank after reset, busy=0.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared display codes, segment patterns and helpers
// for the four-digit 7-segment scan driver.
package seg7_scan_driver_pkg;

    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_MINUS = 4'hB;
    localparam logic [3:0] CODE_DASH  = CODE_MINUS;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } conv_state_t;

    typedef logic [DIGITS-1:0][3:0] disp_t;

    // Add 3 to every BCD nibble that is 5 or more,
    // so the following left shift carries correctly.
    function automatic logic [BCD_W-1:0] bcd_adjust(
        input logic [BCD_W-1:0] b
    );
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decoder.sv
// Display code to active-low segment pattern.
// Unknown codes fall back to a blank digit.
module seg7_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup from display code to segments
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_BLANK: seg = SEG_BLANK;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Signed magnitude to 4-digit multiplexed 7-segment display:
// sequential shift-add-3 BCD conversion plus digit scanning.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int MAG_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] value,
    input  logic             negative,
    input  logic             load,
    output logic             busy,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int RW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW    = $clog2(MAG_W + 1);
    localparam int ACC_W = BCD_W + MAG_W;

    conv_state_t       state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [MAG_W-1:0]  mag_q;
    logic              neg_q;
    logic [SW-1:0]     step;
    disp_t             disp;
    disp_t             fmt;
    logic [BCD_W-1:0]  bcd;
    logic [DIGITS-1:0] lead;
    logic              ovf;

    logic [RW-1:0]     rcnt;
    logic [1:0]        idx;
    logic              wrap;
    logic              wrap_q;
    logic              started;
    logic [6:0]        seg_nxt;

    assign dp  = 1'b1;
    assign bcd = acc[MAG_W +: BCD_W];

    assign acc_adj = {bcd_adjust(bcd), acc[MAG_W-1:0]};

    assign ovf = (32'(mag_q) > 32'd9999) ||
                 (neg_q && (32'(mag_q) > 32'd999));

    // Blank leading zeros, place the minus, or dash out overflow
    always_comb begin
        lead = '0;
        fmt  = '0;
        lead[DIGITS-1] = (bcd[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--)
            lead[i] = lead[i+1] && (bcd[4*i +: 4] == 4'd0);
        for (int i = 0; i < DIGITS; i++)
            fmt[i] = lead[i] ? CODE_BLANK : bcd[4*i +: 4];
        if (neg_q && (mag_q != '0)) begin
            for (int i = 1; i < DIGITS; i++)
                if (lead[i] && !lead[i-1])
                    fmt[i] = CODE_MINUS;
        end
        if (ovf) begin
            for (int i = 0; i < DIGITS; i++)
                fmt[i] = CODE_DASH;
        end
    end

    // Conversion FSM: capture, MAG_W shifts, then commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            mag_q <= '0;
            neg_q <= 1'b0;
            step  <= '0;
            for (int i = 0; i < DIGITS; i++)
                disp[i] <= CODE_BLANK;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        acc   <= {{BCD_W{1'b0}}, value};
                        mag_q <= value;
                        neg_q <= negative;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    acc  <= acc_adj << 1;
                    step <= step + SW'(1);
                    if (step == SW'(MAG_W - 1))
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp  <= fmt;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wrap = (rcnt == RW'(REFRESH_DIV - 1));

    seg7_decoder u_dec (
        .code (disp[idx]),
        .seg  (seg_nxt)
    );

    // Refresh divider, scan index and registered digit outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt    <= '0;
            idx     <= '0;
            wrap_q  <= 1'b0;
            started <= 1'b0;
            an      <= 4'hF;
            seg     <= SEG_BLANK;
        end else begin
            wrap_q <= wrap;
            if (wrap) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            if (wrap_q)
                started <= 1'b1;
            if (wrap_q || started) begin
                an  <= ~(4'b0001 << idx);
                seg <= seg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a
// short refresh divider.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        negative;
    logic        load;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .MAG_W       (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .negative (negative),
        .load     (load),
        .busy     (busy),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic read_digit(input int idx,
                              output logic [6:0] s,
                              output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        ok = 1'b0;
        s = 7'h00;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (an === want) begin
                ok = 1'b1;
                s = seg;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [13:0] v, input logic n);
        @(negedge clk);
        value = v;
        negative = n;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle timeout busy=%b want 0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [6:0] s;
        bit ok;
        rst = 1'b1;
        load = 1'b0;
        value = '0;
        negative = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_state an=%h seg=%h busy=%b dp=%b want F 7F 0 1",
                     an, seg, busy, dp);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL pre_wrap_an got %h want F", an);
        end
        read_digit(1, s, ok);
        checks++;
        if (!ok || s !== 7'h7F) begin
            errors++;
            $display("FAIL blank_after_reset ok=%0d seg=%h want 7F", ok, s);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset an=%h seg=%h busy=%b want F 7F 0",
                     an, seg, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_convert_1234;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        int n;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        @(negedge clk);
        value = 14'd1234;
        negative = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len got %0d want 15", n);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++;
                $display("FAIL v1234 an%0d ok=%0d seg=%h want %h",
                         i, ok, s, exp_seg[i]);
            end
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++;
            $display("FAIL dp got %b want 1", dp);
        end
    endtask

    task automatic test_negative;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        exp_seg = '{7'h78, 7'h3F, 7'h7F, 7'h7F};
        do_load(14'd7, 1'b1);
        wait_idle("neg7");
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++;
                $display("FAIL neg7 an%0d ok=%0d seg=%h want %h",
                         i, ok, s, exp_seg[i]);
            end
        end
        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        do_load(14'd0, 1'b1);
        wait_idle("negzero");
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++;
                $display("FAIL negzero an%0d ok=%0d seg=%h want %h",
                         i, ok, s, exp_seg[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [6:0] s;
        bit ok;
        do_load(14'd10000, 1'b0);
        wait_idle("ovf10000");
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== 7'h3F) begin
                errors++;
                $display("FAIL ovf10000 an%0d ok=%0d seg=%h want 3F", i, ok, s);
            end
        end
        do_load(14'd42, 1'b0);
        wait_idle("clear");
        do_load(14'd1000, 1'b1);
        wait_idle("ovfneg1000");
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== 7'h3F) begin
                errors++;
                $display("FAIL ovfneg1000 an%0d ok=%0d seg=%h want 3F", i, ok, s);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        exp_seg = '{7'h24, 7'h19, 7'h7F, 7'h7F};
        @(negedge clk);
        value = 14'd42;
        negative = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        value = 14'd99;
        load = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy got %b want 1", busy);
        end
        @(negedge clk);
        load = 1'b0;
        wait_idle("b2b");
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queue busy=%b want 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== exp_seg[i]) begin
                errors++;
                $display("FAIL b2b an%0d ok=%0d seg=%h want %h",
                         i, ok, s, exp_seg[i]);
            end
        end
    endtask

    task automatic test_reset_mid_convert;
        logic [6:0] s;
        bit ok;
        do_load(14'd5555, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || an !== 4'hF || seg !== 7'h7F) begin
            errors++;
            $display("FAIL abort_reset busy=%b an=%h seg=%h want 0 F 7F",
                     busy, an, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            read_digit(i, s, ok);
            checks++;
            if (!ok || s !== 7'h7F) begin
                errors++;
                $display("FAIL abort_blank an%0d ok=%0d seg=%h want 7F", i, ok, s);
            end
        end
    endtask

    initial begin
        test_reset;
        test_convert_1234;
        test_negative;
        test_overflow;
        test_back_to_back;
        test_reset_mid_convert;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
